// File: rtl/adder_seq_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : adder_seq_accumulator (with helper adder_n)
//  Description : Multi-cycle accumulator that time-shares a single N-bit
//                ripple adder to sum K captured N-bit operands. Intended for
//                Game of Life neighbour counting, where eight 1-bit
//                neighbours are zero-extended to 4 bits and summed serially
//                instead of through an adder tree.
//
//  Ports       : clk      - rising-edge clock
//                rst      - synchronous active-high reset
//                start    - run request, sampled only while ready=1
//                operands - K packed operands, operand i at [N*i +: N]
//                ready    - high only in IDLE
//                busy     - high while accumulating
//                valid    - one-cycle pulse, sum/overflow are final
//                sum      - accumulated result, held until the next run
//                overflow - sticky OR of every adder carry-out in the run
//
//  Build option: SATURATE_EN - when defined, the accumulator clamps to
//                all-ones after the first carry-out of a run and stays there
//                for the rest of that run. Handshake timing is unchanged.
//
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  adder_n : plain N-bit ripple-carry adder
//    a, b  - addends          c_in  - carry in
//    sum   - N-bit sum        c_out - carry out of the MSB
// ----------------------------------------------------------------------------
module adder_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    logic [N:0] w_carry;

    assign w_carry[0] = c_in;

    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        assign sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
        assign w_carry[gi+1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
    end

    assign c_out = w_carry[N];

endmodule

// ----------------------------------------------------------------------------
//  adder_seq_accumulator : top level
//    N  >= 1 : operand / accumulator width
//    K  >= 1 : operands per run
//    IW      : operand index width, at least one bit
// ----------------------------------------------------------------------------
module adder_seq_accumulator #(
    parameter int N  = 4,
    parameter int K  = 8,
    parameter int IW = (K > 1) ? $clog2(K) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*K-1:0] operands,
    output logic           ready,
    output logic           busy,
    output logic           valid,
    output logic [N-1:0]   sum,
    output logic           overflow
);

    // Index of the final operand; reaching it in ACCUM ends the run.
    localparam logic [IW-1:0] c_LAST_IDX = IW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [N*K-1:0]  r_operands;
    logic [N-1:0]    r_acc;
    logic            r_overflow;
    logic [IW-1:0]   r_idx;

    logic [N-1:0]    w_ops [K];
    logic [N-1:0]    w_operand;
    logic [N-1:0]    w_add_sum;
    logic            w_add_cout;
    logic [N-1:0]    w_acc_next;
    logic            w_last;

    // ------------------------------------------------------------------
    //  Operand selection: unpack the captured bus into an array so the
    //  running index picks one operand per cycle.
    // ------------------------------------------------------------------
    for (genvar gk = 0; gk < K; gk++) begin : g_op
        assign w_ops[gk] = r_operands[N*gk +: N];
    end

    assign w_operand = w_ops[r_idx];
    assign w_last    = (r_idx == c_LAST_IDX);

    // ------------------------------------------------------------------
    //  The single shared adder: acc + operand[idx], no carry in.
    // ------------------------------------------------------------------
    adder_n #(
        .N (N)
    ) u_adder (
        .a     (r_acc),
        .b     (w_operand),
        .c_in  (1'b0),
        .sum   (w_add_sum),
        .c_out (w_add_cout)
    );

    // ------------------------------------------------------------------
    //  Next accumulator value. In the saturating build, any carry seen so
    //  far in the run (including this step) pins the accumulator at its
    //  maximum; later adds from that maximum are discarded.
    // ------------------------------------------------------------------
`ifdef SATURATE_EN
    always_comb begin
        w_acc_next = w_add_sum;
        if (r_overflow || w_add_cout) begin
            w_acc_next = {N{1'b1}};
        end
    end
`else
    assign w_acc_next = w_add_sum;
`endif

    // ------------------------------------------------------------------
    //  State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    //  Next-state and handshake outputs. Outputs decode the registered
    //  state only, so they are glitch-free with respect to inputs.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        valid        = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                valid        = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    //  Datapath. Operands are captured only on an accepted start, so bus
    //  changes during a run have no effect. sum/overflow are left alone in
    //  IDLE and DONE so the last result stays visible until the next run.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_operands <= '0;
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_idx      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_operands <= operands;
                        r_acc      <= '0;
                        r_overflow <= 1'b0;
                        r_idx      <= '0;
                    end
                end
                S_ACCUM: begin
                    r_acc      <= w_acc_next;
                    r_overflow <= r_overflow | w_add_cout;
                    // Park the index at 0 after the final add so it never
                    // walks past the last operand.
                    if (w_last) begin
                        r_idx <= '0;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum      = r_acc;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_adder_seq_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_seq_accumulator
//  Description : Self-checking bench for adder_seq_accumulator (N=4, K=8).
//                Directed runs plus randomized operand sets, each compared
//                against an arithmetic reference of the serial sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_seq_accumulator;

    localparam int N = 4;
    localparam int K = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N*K-1:0] operands;
    logic           ready;
    logic           busy;
    logic           valid;
    logic [N-1:0]   sum;
    logic           overflow;

    int n_vec;
    int n_err;

    adder_seq_accumulator #(
        .N (N),
        .K (K)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .operands (operands),
        .ready    (ready),
        .busy     (busy),
        .valid    (valid),
        .sum      (sum),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: add the operands one after another in plain integer
    // arithmetic, wrapping at 2^N and noting any step that crosses 2^N.
    task automatic model(input logic [N*K-1:0] ops, output logic [N-1:0] es, output logic eo);
        int acc;
        int t;
        int top;
        bit ov;
        top = 1 << N;
        acc = 0;
        ov  = 1'b0;
        for (int i = 0; i < K; i++) begin
            t = acc + int'(ops[N*i +: N]);
            if (t >= top) ov = 1'b1;
            acc = t % top;
`ifdef SATURATE_EN
            if (ov) acc = top - 1;
`endif
        end
        es = acc[N-1:0];
        eo = ov;
    endtask

    function automatic logic [N*K-1:0] fill(input int v);
        logic [N*K-1:0] r;
        for (int i = 0; i < K; i++) r[N*i +: N] = v[N-1:0];
        return r;
    endfunction

    // One complete run. With inject set, a second start with different
    // operands is pulsed mid-run and the tail is watched for stray pulses.
    task automatic run_and_check(input logic [N*K-1:0] ops, input string tag, input bit inject);
        logic [N-1:0] es;
        logic         eo;
        int           cycles;
        int           pulses;
        model(ops, es, eo);
        @(negedge clk);
        operands = ops;
        start    = 1'b1;
        @(negedge clk);
        cycles = 1;
        start  = 1'b0;
        check_eq({tag, ".busy"}, busy, 1);
        check_eq({tag, ".ready_busy"}, ready, 0);
        while (!valid && cycles < 40) begin
            if (inject) begin
                operands = ~ops;
                start    = (cycles == 3);
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check_eq({tag, ".latency"}, cycles, K + 1);
        check_eq({tag, ".sum"}, sum, es);
        check_eq({tag, ".ovf"}, overflow, eo);
        @(negedge clk);
        check_eq({tag, ".ready_after"}, ready, 1);
        check_eq({tag, ".sum_held"}, sum, es);
        if (inject) begin
            pulses = 0;
            for (int i = 0; i < 12; i++) begin
                if (valid) pulses++;
                @(negedge clk);
            end
            check_eq({tag, ".extra_valid"}, pulses, 0);
        end
    endtask

    initial begin
        logic [N*K-1:0] ops;
        logic [N-1:0]   es;
        logic           eo;
        int             cycles;
        int             pulses;
        int             last_pulse;

        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        operands = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst.ready", ready, 1);
        check_eq("rst.busy", busy, 0);
        check_eq("rst.valid", valid, 0);
        check_eq("rst.sum", sum, 0);
        check_eq("rst.ovf", overflow, 0);

        // Directed operand sets
        run_and_check(fill(0), "zeros", 1'b0);
        run_and_check(fill(1), "all_alive", 1'b0);
        ops = '0;
        ops[N*0 +: N] = 1; ops[N*1 +: N] = 1; ops[N*2 +: N] = 1;
        run_and_check(ops, "three", 1'b0);
        ops = '0;
        ops[N*0 +: N] = 15; ops[N*1 +: N] = 1;
        run_and_check(ops, "wrap_15_1", 1'b0);
        run_and_check(fill(15), "all_15", 1'b0);

        // Start pulsed during ACCUM must be ignored
        run_and_check(fill(1), "inject", 1'b1);

        // Reset during the 4th ACCUM cycle aborts the run
        @(negedge clk);
        operands = fill(3);
        start    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (cycles < 4) begin
            @(negedge clk);
            cycles++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort.ready", ready, 1);
        check_eq("abort.busy", busy, 0);
        check_eq("abort.sum", sum, 0);
        check_eq("abort.ovf", overflow, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (valid) pulses++;
            @(negedge clk);
        end
        check_eq("abort.no_valid", pulses, 0);

        // Continuous start: back-to-back runs, one every K+2 cycles
        model(fill(2), es, eo);
        operands   = fill(2);
        start      = 1'b1;
        pulses     = 0;
        last_pulse = -1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (valid) begin
                pulses++;
                check_eq("cont.sum", sum, es);
                check_eq("cont.ovf", overflow, eo);
                if (last_pulse >= 0) check_eq("cont.gap", c - last_pulse, K + 2);
                last_pulse = c;
            end
        end
        start = 1'b0;
        check_eq("cont.pulses", pulses, 4);
        repeat (15) @(negedge clk);

        // Randomized runs: half with 1-bit neighbours, half full range
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < K; i++) begin
                if (r < 12) ops[N*i +: N] = N'($urandom_range(0, 1));
                else        ops[N*i +: N] = N'($urandom);
            end
            run_and_check(ops, "rand", 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
